// File: rtl/traffic_phase_ctrl_pkg.sv
// Shared light codes, phase encoding and the phase -> lamp decode
// for the intersection sequencer.
package traffic_pkg;

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_GREEN  = 2'b10;
  localparam logic [1:0] LIGHT_OFF    = 2'b11;

  typedef enum logic [2:0] {
    PH_INIT  = 3'd0,
    PH_MG    = 3'd1,
    PH_MGF   = 3'd2,
    PH_Y1    = 3'd3,
    PH_CG    = 3'd4,
    PH_CGF   = 3'd5,
    PH_Y2    = 3'd6,
    PH_NIGHT = 3'd7
  } phase_e;

  // Returns {light, flicker}; LIGHT_OFF is deliberately never produced.
  function automatic logic [2:0] lamp_of(input logic [2:0] ph);
    logic [2:0] v;
    case (ph)
      PH_MG:   v = {LIGHT_GREEN,  1'b0};
      PH_MGF:  v = {LIGHT_GREEN,  1'b1};
      PH_Y1:   v = {LIGHT_YELLOW, 1'b0};
      PH_CG:   v = {LIGHT_RED,    1'b0};
      PH_CGF:  v = {LIGHT_RED,    1'b1};
      PH_Y2:   v = {LIGHT_YELLOW, 1'b0};
      default: v = {LIGHT_YELLOW, 1'b1};
    endcase
    return v;
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_if.sv
// Control inputs and lamp/display outputs of the intersection sequencer.
interface traffic_phase_ctrl_if #(parameter int CNT_W = 8);
  logic             tick;
  logic             en;
  logic             night;
  logic             cross_req;
  logic [1:0]       light;
  logic             flicker;
  logic [CNT_W-1:0] remain;
  logic [2:0]       phase;

  modport master (output tick, en, night, cross_req,
                  input  light, flicker, remain, phase);
  modport slave  (input  tick, en, night, cross_req,
                  output light, flicker, remain, phase);
endinterface

// File: rtl/traffic_phase_ctrl_timer.sv
// Phase down-counter; load has priority over the tick decrement.
module phase_timer #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_tick_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_last
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_cnt <= RST_VAL;
    else if (i_load)    r_cnt <= i_load_val;
    else if (i_tick_en) r_cnt <= r_cnt - 1'b1;
  end

  assign o_cnt  = r_cnt;
  assign o_last = (r_cnt == CNT_W'(1)) && i_tick_en;

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Main/cross intersection sequencer with cross request clamp and night flash.
//
// state | meaning
// INIT  | startup yellow flash
// MG    | main green, steady
// MGF   | main green, flashing
// Y1    | yellow, main -> cross
// CG    | cross green, steady
// CGF   | cross green, flashing
// Y2    | yellow, cross -> main
// NIGHT | flashing yellow until night drops
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int CNT_W         = 8,
  parameter int T_MAIN_GREEN  = 30,
  parameter int T_CROSS_GREEN = 20,
  parameter int T_FLICKER     = 3,
  parameter int T_YELLOW      = 3,
  parameter int T_REQ_CAP     = 5
) (
  input logic clk,
  input logic rst_n,
  traffic_phase_ctrl_if.slave s_bus
);

  localparam logic [2:0] S_INIT  = PH_INIT;
  localparam logic [2:0] S_MG    = PH_MG;
  localparam logic [2:0] S_MGF   = PH_MGF;
  localparam logic [2:0] S_Y1    = PH_Y1;
  localparam logic [2:0] S_CG    = PH_CG;
  localparam logic [2:0] S_CGF   = PH_CGF;
  localparam logic [2:0] S_Y2    = PH_Y2;
  localparam logic [2:0] S_NIGHT = PH_NIGHT;

  function automatic logic [CNT_W-1:0] dur_of(input logic [2:0] s);
    logic [CNT_W-1:0] d;
    case (s)
      S_MG:          d = CNT_W'(T_MAIN_GREEN);
      S_CG:          d = CNT_W'(T_CROSS_GREEN);
      S_MGF, S_CGF:  d = CNT_W'(T_FLICKER);
      S_NIGHT:       d = '0;
      default:       d = CNT_W'(T_YELLOW);
    endcase
    return d;
  endfunction

  function automatic logic [2:0] succ_of(input logic [2:0] s);
    logic [2:0] n;
    case (s)
      S_INIT:  n = S_MG;
      S_MG:    n = S_MGF;
      S_MGF:   n = S_Y1;
      S_Y1:    n = S_CG;
      S_CG:    n = S_CGF;
      S_CGF:   n = S_Y2;
      S_Y2:    n = S_MG;
      default: n = S_INIT;
    endcase
    return n;
  endfunction

  logic [2:0]       r_state;
  logic [1:0]       r_light;
  logic             r_flicker;
  logic             r_req;
  logic [2:0]       w_next;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_tick_en;
  logic             w_last;
  logic [CNT_W-1:0] w_cnt;

  assign w_tick_en = s_bus.en && s_bus.tick && !s_bus.night && (r_state != S_NIGHT);

  phase_timer #(.CNT_W(CNT_W), .RST_VAL(CNT_W'(T_YELLOW))) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_load),
    .i_load_val(w_load_val),
    .i_tick_en (w_tick_en),
    .o_cnt     (w_cnt),
    .o_last    (w_last)
  );

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    if (s_bus.night) begin
      w_next = S_NIGHT;
      w_load = 1'b1;
    end else if (r_state == S_NIGHT) begin
      w_next     = S_Y2;
      w_load     = 1'b1;
      w_load_val = dur_of(S_Y2);
    end else if (w_last) begin
      w_next     = succ_of(r_state);
      w_load     = 1'b1;
      w_load_val = dur_of(w_next);
    end else if (w_tick_en && r_state == S_MG && r_req &&
                 w_cnt > CNT_W'(T_REQ_CAP)) begin
      // A pending request only ever shortens main green.
      w_load     = 1'b1;
      w_load_val = CNT_W'(T_REQ_CAP);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_INIT;
      r_light   <= LIGHT_YELLOW;
      r_flicker <= 1'b1;
      r_req     <= 1'b0;
    end else begin
      r_state              <= w_next;
      {r_light, r_flicker} <= lamp_of(w_next);
      if (w_next == S_CG && r_state != S_CG) r_req <= 1'b0;
      else                                   r_req <= r_req | s_bus.cross_req;
    end
  end

  assign s_bus.light   = r_light;
  assign s_bus.flicker = r_flicker;
  assign s_bus.remain  = w_cnt;
  assign s_bus.phase   = r_state;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl with short phase durations.
module tb_traffic_phase_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  traffic_phase_ctrl_if #(.CNT_W(8)) bus ();

  traffic_phase_ctrl #(
    .CNT_W(8), .T_MAIN_GREEN(5), .T_CROSS_GREEN(4),
    .T_FLICKER(2), .T_YELLOW(2), .T_REQ_CAP(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .s_bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Lamp table written out from the phase list: {light, flicker}.
  function automatic logic [2:0] exp_lamp(input int ph);
    case (ph)
      1:       return 3'b10_0;
      2:       return 3'b10_1;
      3:       return 3'b01_0;
      4:       return 3'b00_0;
      5:       return 3'b00_1;
      6:       return 3'b01_0;
      default: return 3'b01_1;
    endcase
  endfunction

  task automatic chk_st(input string tag, input int ph, input int rem);
    logic [2:0] lf;
    lf = exp_lamp(ph);
    chk({tag, ".phase"},   32'(bus.phase),   32'(ph));
    chk({tag, ".remain"},  32'(bus.remain),  32'(rem));
    chk({tag, ".light"},   32'(bus.light),   32'(lf[2:1]));
    chk({tag, ".flicker"}, 32'(bus.flicker), 32'(lf[0]));
  endtask

  // Called at a negedge; returns at a negedge four clocks later.
  task automatic do_tick();
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_req();
    bus.cross_req = 1'b1;
    @(negedge clk);
    bus.cross_req = 1'b0;
  endtask

  int seq_ph  [21] = '{0,1,1,1,1,1,2,2,3,3,4,4,4,4,5,5,6,6,1,1,1};
  int seq_rem [21] = '{1,5,4,3,2,1,2,1,2,1,4,3,2,1,2,1,2,1,5,4,3};

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.tick      = 1'b0;
    bus.en        = 1'b1;
    bus.night     = 1'b0;
    bus.cross_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: reset state and full cycle
    chk_st("reset", 0, 2);
    chk("reset.req", 32'(dut.r_req), 0);
    for (int i = 0; i < 21; i++) begin
      do_tick();
      chk_st($sformatf("seq%0d", i + 1), seq_ph[i], seq_rem[i]);
    end

    // 2: request at MG remain=5 clamps to 2
    repeat (15) do_tick();
    chk_st("mg2", 1, 5);
    pulse_req();
    chk("req.set", 32'(dut.r_req), 1);
    do_tick();  chk_st("clamp", 1, 2);
    do_tick();  chk_st("clamp1", 1, 1);
    do_tick();  chk_st("clamp.mgf", 2, 2);
    repeat (4) do_tick();
    chk_st("cg.entry", 4, 4);
    chk("req.clr", 32'(dut.r_req), 0);
    do_tick();  chk_st("cg3", 4, 3);

    // 4: freeze during CG
    bus.en = 1'b0;
    repeat (3) do_tick();
    chk_st("freeze", 4, 3);
    bus.en = 1'b1;
    do_tick();  chk_st("unfreeze", 4, 2);
    repeat (6) do_tick();
    chk_st("mg3", 1, 5);
    do_tick();  chk_st("mg3.4", 1, 4);
    do_tick();  chk_st("mg3.3", 1, 3);
    do_tick();  chk_st("mg3.2", 1, 2);

    // 3: late request does not clamp
    pulse_req();
    do_tick();  chk_st("late1", 1, 1);
    do_tick();  chk_st("late.mgf", 2, 2);

    // 5: night coincident with tick
    bus.night = 1'b1;
    bus.tick  = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    chk_st("night", 7, 0);
    chk("night.req", 32'(dut.r_req), 1);
    repeat (5) do_tick();
    chk_st("night.hold", 7, 0);
    bus.night = 1'b0;
    @(negedge clk);
    chk_st("night.exit", 6, 2);
    do_tick();  chk_st("y2.1", 6, 1);
    do_tick();  chk_st("mg4", 1, 5);

    // 6: async reset mid-CG
    repeat (7) do_tick();
    chk_st("cg4", 4, 4);
    do_tick();  chk_st("cg4.3", 4, 3);
    pulse_req();
    chk("req.pre", 32'(dut.r_req), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_st("arst", 0, 2);
    chk("arst.req", 32'(dut.r_req), 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
